// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencer: owns the FETCH..HALT state bus, the PC, the retired
// counter and the link register, and decodes per-stage strobes from state.
module mc_control_fsm #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic [1:0]      format,
  input  logic [5:0]      opcode,
  input  logic [15:0]     immediate,
  input  logic [25:0]     target,
  input  logic            alu_zero,
  output logic [2:0]      state,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            ir_load,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic            halted,
  output logic [31:0]     retired,
  output logic [PC_W-1:0] link
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_JAL, C_HALT, C_NOP
  } cls_t;

  state_t          r_state, w_next;
  cls_t            r_cls, w_cls;
  logic [PC_W-1:0] r_pc, r_link;
  logic [31:0]     r_retired;
  logic            w_taken;
  logic [PC_W-1:0] w_br_off;
  logic            w_retire;

  // Instruction class straight from the decoder; only meaningful in EXECUTE.
  always_comb begin
    w_cls = C_ALU;
    case (format)
      2'd0: w_cls = C_ALU;
      2'd1: w_cls = C_JAL;
      2'd3: w_cls = C_NOP;
      default: begin
        case (opcode)
          6'd35:  w_cls = C_LW;
          6'd43:  w_cls = C_SW;
          6'd4:   w_cls = C_BEQ;
          6'd5:   w_cls = C_BNE;
          6'h3F:  w_cls = C_HALT;
          default: w_cls = C_ALU;
        endcase
      end
    endcase
  end

  assign w_taken  = (w_cls == C_BEQ && alu_zero) || (w_cls == C_BNE && !alu_zero);
  assign w_br_off = {{(PC_W-18){immediate[15]}}, immediate, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (imem_ready) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (w_cls)
          C_ALU, C_JAL: w_next = S_WB;
          C_LW,  C_SW:  w_next = S_MEM;
          C_HALT:       w_next = S_HALT;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_ready) w_next = (r_cls == C_LW) ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end

  // Only instruction completions count; DECODE and HALT never reach FETCH.
  assign w_retire = (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) &&
                    (w_next == S_FETCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_link    <= '0;
      r_cls     <= C_NOP;
      r_retired <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ready) r_pc <= r_pc + PC_W'(4);
      if (r_state == S_EXEC) begin
        r_cls <= w_cls;
        if (w_taken) r_pc <= r_pc + w_br_off;
        if (w_cls == C_JAL) begin
          r_link <= r_pc;
          r_pc   <= {r_pc[PC_W-1:28], target, 2'b00};
        end
      end
      if (w_retire) r_retired <= r_retired + 32'd1;
    end
  end

  always_comb begin
    imem_req = (r_state == S_FETCH);
    ir_load  = (r_state == S_FETCH) && imem_ready;
    dmem_req = (r_state == S_MEM);
    dmem_we  = (r_state == S_MEM) && (r_cls == C_SW);
    reg_we   = (r_state == S_WB);
    halted   = (r_state == S_HALT);
    wb_sel   = (r_cls == C_LW) ? 2'd1 : (r_cls == C_JAL) ? 2'd2 : 2'd0;
  end

  assign state   = r_state;
  assign pc      = r_pc;
  assign retired = r_retired;
  assign link    = r_link;

endmodule
